// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 32;

  // Records which requester owns the read response in the following cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2,
    OWN_ERR   = 2'd3
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory-side signals of the memory port arbiter.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              mem_ce;
  logic              mem_wre;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  // Arbiter view: core requests and memory read data in, everything else out.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    output mem_ce, mem_wre, mem_ad, mem_din
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_ce, mem_wre, mem_ad, mem_din
  );

endinterface

// File: rtl/mem_port_arbiter_prio_sel.sv
// Combinational priority select: data first, fetch once the data streak is full.
module arb_prio_sel
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic streak_full,
  output logic gnt_if,
  output logic gnt_d
);

  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (d_req && !(if_req && streak_full)) begin
      gnt_d = 1'b1;
    end else if (if_req) begin
      gnt_if = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between instruction fetch and load/store,
// steering each read response back to its owner one cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = MEM_ADDR_W,
  parameter int DATA_W          = MEM_DATA_W,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  localparam int                  STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  owner_t              own_q, own_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                streak_full;
  logic                sel_if, sel_d;
  logic                if_gnt, d_gnt;
  logic                misaligned;

  assign streak_full = (streak_q == STREAK_MAX);
  assign misaligned  = (bus.d_addr[1:0] != 2'b00);

  arb_prio_sel u_sel (
    .if_req      (bus.if_req),
    .d_req       (bus.d_req),
    .streak_full (streak_full),
    .gnt_if      (sel_if),
    .gnt_d       (sel_d)
  );

  // Grants are forced low while reset is held so nothing reaches the memory.
  assign if_gnt = sel_if & rst;
  assign d_gnt  = sel_d & rst;

  always_comb begin
    bus.mem_ce  = 1'b0;
    bus.mem_wre = 1'b0;
    bus.mem_ad  = '0;
    bus.mem_din = '0;
    own_d       = OWN_NONE;
    if (if_gnt) begin
      bus.mem_ce = 1'b1;
      bus.mem_ad = bus.if_addr;
      own_d      = OWN_FETCH;
    end else if (d_gnt) begin
      if (misaligned) begin
        own_d = OWN_ERR;
      end else begin
        bus.mem_ce  = 1'b1;
        bus.mem_wre = bus.d_we;
        bus.mem_ad  = bus.d_addr;
        bus.mem_din = bus.d_wdata;
        own_d       = bus.d_we ? OWN_NONE : OWN_DATA;
      end
    end
  end

  // Streak only grows while fetch is actually waiting behind data.
  always_comb begin
    streak_d = streak_q;
    if (!bus.if_req || if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && !streak_full) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_q    <= OWN_NONE;
      streak_q <= '0;
    end else begin
      own_q    <= own_d;
      streak_q <= streak_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rvalid = (own_q == OWN_FETCH);
  assign bus.d_rvalid  = (own_q == OWN_DATA);
  assign bus.d_err     = (own_q == OWN_ERR);
  assign bus.if_rdata  = bus.mem_dout;
  assign bus.d_rdata   = bus.mem_dout;

endmodule
